// File: rtl/monitor_read_sched.sv
// Shares the monitor register file read port between host reads and a snapshot engine that dumps a register block into a local buffer.
// Latency: each read takes 3 cycles (grant, issue, capture); host_ack follows a granted host_req by 3 cycles.
// Backpressure: host_req is held until host_ack; snap_trig during a running snapshot is dropped and reported on snap_overrun.
module monitor_read_sched #(
  parameter int          NUM_SNAP  = 13,
  parameter logic [15:0] SNAP_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic [15:0] host_addr,
  output logic        host_ack,
  output logic [15:0] host_data,
  input  logic        snap_trig,
  output logic        snap_busy,
  output logic        snap_done,
  output logic        snap_valid,
  output logic        snap_overrun,
  input  logic [3:0]  snap_rd_idx,
  output logic [15:0] snap_rd_data,
  output logic        mon_read_en,
  output logic [15:0] mon_addr,
  input  logic [15:0] mon_data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_SNAP - 1);
  localparam logic [4:0] SNAP_CNT = 5'(NUM_SNAP);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_snap;   // current transaction belongs to the snapshot engine
  logic        prio_snap;    // round-robin: snapshot wins the next tie
  logic [3:0]  idx;
  logic        valid_q;
  logic [15:0] buffer [16];
  logic        host_pend;
  logic        snap_pend;
  logic        grant_host;
  logic        grant_snap;

  // The ack cycle itself is not a request; a level still high afterwards is a new one.
  assign host_pend = host_req & ~host_ack;
  // The snapshot only competes from the cycle after its trigger.
  assign snap_pend = snap_busy;
  // A trigger landing on snap_done restarts the dump, so the finished one is never advertised.
  assign snap_valid = valid_q & ~(snap_done & snap_trig);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, arbitration and read strobe
  always_comb begin
    state_nxt   = state;
    grant_host  = 1'b0;
    grant_snap  = 1'b0;
    mon_read_en = 1'b0;
    case (state)
      IDLE: begin
        if (host_pend && (!snap_pend || !prio_snap)) begin
          grant_host = 1'b1;
          state_nxt  = ISSUE;
        end else if (snap_pend) begin
          grant_snap = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        mon_read_en = 1'b1;
        state_nxt   = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch owner and address on grant; mon_addr then holds through capture and idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_snap <= 1'b0;
      prio_snap  <= 1'b0;
      mon_addr   <= '0;
    end else if (grant_host || grant_snap) begin
      owner_snap <= grant_snap;
      prio_snap  <= grant_host;
      mon_addr   <= grant_host ? host_addr : SNAP_BASE + {12'd0, idx};
    end
  end

  // Host capture: single-cycle ack, data held until the next host read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_ack  <= 1'b0;
      host_data <= '0;
    end else begin
      host_ack <= 1'b0;
      if (state == CAPTURE && !owner_snap) begin
        host_ack  <= 1'b1;
        host_data <= mon_data;
      end
    end
  end

  // Snapshot engine: trigger handling, buffer fill and completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_busy    <= 1'b0;
      snap_done    <= 1'b0;
      snap_overrun <= 1'b0;
      valid_q      <= 1'b0;
      idx          <= '0;
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else begin
      snap_done    <= 1'b0;
      snap_overrun <= 1'b0;
      // A snapshot capture only happens while busy, so it never collides with an accepted trigger.
      if (state == CAPTURE && owner_snap) begin
        buffer[idx] <= mon_data;
        if (idx == LAST_IDX) begin
          snap_done <= 1'b1;
          snap_busy <= 1'b0;
          valid_q   <= 1'b1;
          idx       <= '0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
      if (snap_trig) begin
        if (snap_busy) begin
          snap_overrun <= 1'b1;
        end else begin
          snap_busy <= 1'b1;
          valid_q   <= 1'b0;
          idx       <= '0;
        end
      end
    end
  end

  // Registered buffer readout; indices past the snapshot length read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         snap_rd_data <= '0;
    else if ({1'b0, snap_rd_idx} < SNAP_CNT) snap_rd_data <= buffer[snap_rd_idx];
    else                                snap_rd_data <= '0;
  end

endmodule

// File: tb/tb_monitor_read_sched.sv
// Bench for monitor_read_sched: directed scenarios plus a random host/snapshot mix.
// A timestamp-based transaction model predicts every output each cycle.
// Inputs change 1 time unit after posedge; outputs are compared on negedge.
module tb_monitor_read_sched;

  localparam int          NUM_SNAP  = 13;
  localparam logic [15:0] SNAP_BASE = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        host_req;
  logic [15:0] host_addr;
  logic        host_ack;
  logic [15:0] host_data;
  logic        snap_trig;
  logic        snap_busy;
  logic        snap_done;
  logic        snap_valid;
  logic        snap_overrun;
  logic [3:0]  snap_rd_idx;
  logic [15:0] snap_rd_data;
  logic        mon_read_en;
  logic [15:0] mon_addr;
  logic [15:0] mon_data;
  bit          ovr_en;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int done_count = 0;
  int ack_count = 0;

  monitor_read_sched #(.NUM_SNAP(NUM_SNAP), .SNAP_BASE(SNAP_BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack), .host_data(host_data),
    .snap_trig(snap_trig), .snap_busy(snap_busy), .snap_done(snap_done), .snap_valid(snap_valid),
    .snap_overrun(snap_overrun), .snap_rd_idx(snap_rd_idx), .snap_rd_data(snap_rd_data),
    .mon_read_en(mon_read_en), .mon_addr(mon_addr), .mon_data(mon_data)
  );

  // Register file contents seen through the read port.
  function automatic logic [15:0] data_of(input logic [15:0] a, input bit ov);
    if (ov && a == 16'h0003) return 16'h1234;
    return a + 16'h0100;
  endfunction

  assign mon_data = data_of(mon_addr, ovr_en);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc;
  bit          tx_on, tx_host;
  int          tx_g;
  logic [15:0] tx_addr, tx_data;
  logic [3:0]  tx_idx;
  bit          prio_snap_m;
  bit          trig_pend, ovr_pend;
  bit          e_ack, e_done, e_ovr, e_busy, e_valid, e_rden;
  logic [15:0] e_hdata, e_addr, e_rdata, rd_next;
  logic [3:0]  e_idx;
  logic [15:0] buf_m [16];

  task automatic model_reset();
    tx_on = 0; tx_host = 0; tx_g = 0; tx_addr = '0; tx_data = '0; tx_idx = '0;
    prio_snap_m = 0; trig_pend = 0; ovr_pend = 0;
    e_ack = 0; e_done = 0; e_ovr = 0; e_busy = 0; e_valid = 0; e_rden = 0;
    e_hdata = '0; e_addr = '0; e_rdata = '0; rd_next = '0; e_idx = '0;
    for (int i = 0; i < 16; i++) buf_m[i] = '0;
  endtask

  task automatic compare_all();
    chk("host_ack", 16'(host_ack), 16'(e_ack));
    chk("host_data", host_data, e_hdata);
    chk("snap_busy", 16'(snap_busy), 16'(e_busy));
    chk("snap_done", 16'(snap_done), 16'(e_done));
    chk("snap_valid", 16'(snap_valid), 16'(e_valid && !(e_done && snap_trig)));
    chk("snap_overrun", 16'(snap_overrun), 16'(e_ovr));
    chk("snap_rd_data", snap_rd_data, e_rdata);
    chk("mon_read_en", 16'(mon_read_en), 16'(e_rden));
    chk("mon_addr", mon_addr, e_addr);
  endtask

  // One cycle of the model: apply events scheduled for this cycle, compare, then schedule from inputs.
  task automatic model_step();
    bit hp, sp, take_host;
    cyc++;
    e_rden = 0; e_ack = 0; e_done = 0;
    e_ovr = ovr_pend; ovr_pend = 0;
    e_rdata = rd_next;
    if (trig_pend) begin e_busy = 1; e_valid = 0; e_idx = '0; trig_pend = 0; end
    if (tx_on && cyc == tx_g + 1) begin e_rden = 1; e_addr = tx_addr; end
    if (tx_on && cyc == tx_g + 3) begin
      tx_on = 0;
      if (tx_host) begin
        e_ack = 1; e_hdata = tx_data;
      end else begin
        buf_m[tx_idx] = tx_data;
        if (int'(tx_idx) == NUM_SNAP - 1) begin e_done = 1; e_busy = 0; e_valid = 1; end
        else e_idx = tx_idx + 4'd1;
      end
    end
    compare_all();
    if (mon_read_en) rd_count++;
    if (snap_done) done_count++;
    if (host_ack) ack_count++;
    hp = host_req && !e_ack;
    sp = e_busy;
    if (!tx_on && (hp || sp)) begin
      take_host = hp && (!sp || !prio_snap_m);
      tx_on = 1; tx_g = cyc; tx_host = take_host; tx_idx = e_idx;
      tx_addr = take_host ? host_addr : SNAP_BASE + {12'd0, e_idx};
      tx_data = data_of(tx_addr, ovr_en);
      prio_snap_m = take_host;
    end
    if (snap_trig) begin
      if (e_busy) ovr_pend = 1;
      else trig_pend = 1;
    end
    rd_next = (int'(snap_rd_idx) < NUM_SNAP) ? buf_m[snap_rd_idx] : 16'h0000;
  endtask

  // Per-cycle checking against the model; in reset every output must be zero.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      compare_all();
    end else begin
      model_step();
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int limit, output bit ok, output bit saw_valid);
    ok = 0; saw_valid = 0;
    for (int k = 0; k < limit; k++) begin
      snap_rd_idx = 4'($urandom);
      tick(1);
      if (snap_done) begin ok = 1; break; end
      if (snap_valid) saw_valid = 1;
    end
    chk("snap_done_within_bound", 16'(ok), 16'd1);
  endtask

  initial begin
    int rd0, ack0, done0, lat;
    bit ok, saw, got;
    logic [15:0] exp;

    rst_n = 0; host_req = 0; host_addr = '0; snap_trig = 0; snap_rd_idx = '0; ovr_en = 0;
    cyc = 0;
    tick(3);
    rst_n = 1;
    tick(2);

    // 1. Host-only read with latency and single-transaction check.
    ovr_en = 1;
    rd0 = rd_count;
    host_addr = 16'h0003; host_req = 1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (host_ack) begin lat = k; break; end
    end
    host_req = 0;
    chk("t1_ack_latency", 16'(lat), 16'd3);
    chk("t1_host_data", host_data, 16'h1234);
    tick(5);
    chk("t1_single_read", 16'(rd_count - rd0), 16'd1);
    chk("t1_data_held", host_data, 16'h1234);
    ovr_en = 0;

    // 2. Snapshot only, then full buffer readout.
    rd0 = rd_count; done0 = done_count;
    snap_trig = 1; tick(1); snap_trig = 0;
    chk("t2_busy", 16'(snap_busy), 16'd1);
    wait_done(200, ok, saw);
    chk("t2_valid_at_done", 16'(snap_valid), 16'd1);
    for (int i = 0; i < 16; i++) begin
      snap_rd_idx = 4'(i);
      tick(1);
      exp = (i < NUM_SNAP) ? 16'(int'(SNAP_BASE) + i + 256) : 16'h0000;
      chk("t2_readout", snap_rd_data, exp);
    end
    chk("t2_reads", 16'(rd_count - rd0), 16'(NUM_SNAP));
    chk("t2_done_once", 16'(done_count - done0), 16'd1);

    // 3. Contention: host held continuously while a snapshot runs.
    rd0 = rd_count; ack0 = ack_count;
    host_addr = 16'($urandom); host_req = 1; snap_trig = 1;
    tick(1); snap_trig = 0;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (host_ack) host_addr = 16'($urandom);
      if (snap_done) begin ok = 1; break; end
      tick(1);
    end
    chk("t3_done_within_bound", 16'(ok), 16'd1);
    chk("t3_transactions", 16'(rd_count - rd0), 16'(2 * NUM_SNAP));
    chk("t3_host_acks", 16'(ack_count - ack0), 16'(NUM_SNAP));
    got = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (host_ack) begin got = 1; break; end
    end
    host_req = 0;
    chk("t3_final_ack", 16'(got), 16'd1);
    tick(3);

    // 4. Trigger during a running snapshot.
    rd0 = rd_count; done0 = done_count;
    snap_trig = 1; tick(1); snap_trig = 0;
    tick(2 + int'($urandom_range(0, 20)));
    snap_trig = 1; tick(1); snap_trig = 0;
    chk("t4_overrun", 16'(snap_overrun), 16'd1);
    wait_done(200, ok, saw);
    tick(4);
    chk("t4_done_once", 16'(done_count - done0), 16'd1);
    chk("t4_reads", 16'(rd_count - rd0), 16'(NUM_SNAP));

    // 5. Trigger coincident with snap_done.
    snap_trig = 1; tick(1); snap_trig = 0;
    wait_done(200, ok, saw);
    snap_trig = 1; #1;
    chk("t5_valid_masked", 16'(snap_valid), 16'd0);
    tick(1); snap_trig = 0;
    chk("t5_restarted", 16'(snap_busy), 16'd1);
    wait_done(200, ok, saw);
    chk("t5_valid_stayed_low", 16'(saw), 16'd0);
    chk("t5_valid_second_done", 16'(snap_valid), 16'd1);
    tick(2);

    // 6. Reset during a host CAPTURE cycle.
    snap_rd_idx = 4'd3;
    ack0 = ack_count;
    host_addr = 16'($urandom); host_req = 1;
    tick(2);
    #2; rst_n = 0; #1;
    chk("t6_ack", 16'(host_ack), 16'd0);
    chk("t6_host_data", host_data, 16'h0000);
    chk("t6_mon_addr", mon_addr, 16'h0000);
    chk("t6_snap_valid", 16'(snap_valid), 16'd0);
    chk("t6_rd_data", snap_rd_data, 16'h0000);
    host_req = 0;
    tick(2);
    rst_n = 1;
    tick(6);
    chk("t6_no_ack_after", 16'(ack_count - ack0), 16'd0);
    for (int i = 0; i < NUM_SNAP; i++) begin
      snap_rd_idx = 4'(i);
      tick(1);
      chk("t6_buffer_cleared", snap_rd_data, 16'h0000);
    end

    // 7. Random mix of host reads and snapshot triggers.
    for (int k = 0; k < 800; k++) begin
      if (host_req && host_ack) begin
        host_req = 1'($urandom_range(0, 1));
        host_addr = 16'($urandom);
      end else if (!host_req) begin
        host_req = ($urandom_range(0, 3) == 0);
        host_addr = 16'($urandom);
      end
      snap_trig = ($urandom_range(0, 40) == 0);
      snap_rd_idx = 4'($urandom);
      tick(1);
    end
    snap_trig = 0;
    if (host_req) begin
      got = 0;
      for (int k = 0; k < 20; k++) begin
        if (host_ack) begin got = 1; break; end
        tick(1);
      end
      chk("t7_drain_ack", 16'(got), 16'd1);
      host_req = 0;
    end
    tick(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
